frame_buffer_scheduler: RTL and testbench

FRAME_BUFFER_SCHEDULER -- requirements
Module: frame_buffer_scheduler

---
 rtl/fbs_pkg.sv | 22 ++
 rtl/fbs_sat_counter.sv | 25 ++
 rtl/frame_buffer_scheduler.sv | 168 ++++++++++++++++
 tb/tb_frame_buffer_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbs_pkg.sv
// Shared definitions for the frame buffer scheduler.
// Buffer count follows the FBS_TRIPLE_BUFFER_EN macro:
//   defined   -> three buffers (indices 0..2)
//   undefined -> two buffers  (indices 0..1)
package fbs_pkg;

`ifdef FBS_TRIPLE_BUFFER_EN
   localparam int unsigned NUM_BUF = 3;
`else
   localparam int unsigned NUM_BUF = 2;
`endif

   localparam int unsigned IDX_W  = 2;
   localparam int unsigned ADDR_W = 21;

   typedef enum logic [1:0] {
      S_WAIT_CALIB = 2'd0,
      S_IDLE       = 2'd1,
      S_WRITING    = 2'd2
   } fbs_state_e;

endpackage

// File: rtl/fbs_sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
// Ports:
//   PixelClk, nRST : clock, asynchronous active-low reset
//   inc            : count one event this cycle
//   count          : registered count value
module fbs_sat_counter
   import fbs_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             PixelClk,
   input  logic             nRST,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: assigns PSRAM frame buffers to a camera writer and
// an LCD reader so the reader always shows the newest completed frame.
// Build option: FBS_TRIPLE_BUFFER_EN selects three buffers; without it two
// buffers are used and a pending frame is overwritten by the next write.
// Ports:
//   PixelClk, nRST                 : clock, asynchronous active-low reset
//   init_done                      : PSRAM calibration complete (level)
//   wr_frame_start / wr_frame_done : writer frame begin / end pulses
//   rd_frame_start                 : reader frame begin pulse
//   wr_buf_idx / rd_buf_idx        : buffer index owned by writer / reader
//   wr_base_addr / rd_base_addr    : word base address of those buffers
//   wr_active                      : writer currently owns a buffer
//   rd_frame_valid                 : reader has received at least one frame
//   rd_new_frame                   : pulse, reader switched to a new frame
//   drop_cnt / repeat_cnt          : saturating dropped / repeated frame counts
module frame_buffer_scheduler
   import fbs_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = 153600,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              PixelClk,
   input  logic              nRST,
   input  logic              init_done,
   input  logic              wr_frame_start,
   input  logic              wr_frame_done,
   input  logic              rd_frame_start,
   output logic [IDX_W-1:0]  wr_buf_idx,
   output logic [IDX_W-1:0]  rd_buf_idx,
   output logic [ADDR_W-1:0] wr_base_addr,
   output logic [ADDR_W-1:0] rd_base_addr,
   output logic              wr_active,
   output logic              rd_frame_valid,
   output logic              rd_new_frame,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  repeat_cnt
);

   // All buffers must fit in the PSRAM word address space.
   localparam longint unsigned TOTAL_WORDS = 64'(NUM_BUF) * 64'(FRAME_WORDS);
   localparam longint unsigned ADDR_SPAN   = 64'(1) << ADDR_W;

   generate
      if (TOTAL_WORDS > ADDR_SPAN) begin : g_addr_overflow
         $error("frame_buffer_scheduler: buffers exceed the 21-bit address space");
      end
   endgenerate

   localparam logic [ADDR_W-1:0] BASE_0 = '0;
   localparam logic [ADDR_W-1:0] BASE_1 = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] BASE_2 = ADDR_W'(2 * FRAME_WORDS);

   // Constant base address per buffer index.
   function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] idx);
      case (idx)
         2'd1:    base_of = BASE_1;
         2'd2:    base_of = BASE_2;
         default: base_of = BASE_0;
      endcase
   endfunction

   fbs_state_e       state;
   logic [IDX_W-1:0] l_idx;
   logic             l_valid;

   logic             run_c;
   logic             done_c;
   logic             take_c;
   logic             fresh_c;
   logic [IDX_W-1:0] l_1_c;
   logic             lv_1_c;
   logic [IDX_W-1:0] r_2_c;
   logic             lv_2_c;
   logic [IDX_W-1:0] w_3_c;
   logic             lv_3_c;
   logic             drop_inc_c;
   logic             rep_inc_c;

   // Same-cycle events resolve in the order: writer done, reader start, writer start.
   always_comb begin
      run_c      = (state != S_WAIT_CALIB);
      done_c     = (state == S_WRITING) && wr_frame_done;
      l_1_c      = done_c ? wr_buf_idx : l_idx;
      lv_1_c     = done_c || l_valid;
      take_c     = run_c && rd_frame_start && lv_1_c;
      r_2_c      = take_c ? l_1_c : rd_buf_idx;
      lv_2_c     = lv_1_c && !take_c;
      // A start while writing is an abort (same W); after a done it is a fresh frame.
      fresh_c    = wr_frame_start && ((state == S_IDLE) || done_c);
      w_3_c      = wr_buf_idx;
      lv_3_c     = lv_2_c;
      drop_inc_c = done_c && l_valid;
      rep_inc_c  = run_c && rd_frame_start && !lv_1_c && rd_frame_valid;
      if (fresh_c) begin
`ifdef FBS_TRIPLE_BUFFER_EN
         // Lowest index owned neither by the reader nor by the pending frame.
         w_3_c = '0;
         for (int i = NUM_BUF; i > 0; i--) begin
            if ((IDX_W'(i - 1) != r_2_c) && !(lv_2_c && (IDX_W'(i - 1) == l_1_c))) begin
               w_3_c = IDX_W'(i - 1);
            end
         end
`else
         // Only one spare buffer: the pending frame, if any, is overwritten.
         w_3_c = {1'b0, ~r_2_c[0]};
         if (lv_2_c) begin
            lv_3_c     = 1'b0;
            drop_inc_c = 1'b1;
         end
`endif
      end
   end

   // Ownership FSM and registered outputs.
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         state          <= S_WAIT_CALIB;
         wr_buf_idx     <= IDX_W'(1);
         rd_buf_idx     <= '0;
         l_idx          <= '0;
         l_valid        <= 1'b0;
         wr_active      <= 1'b0;
         rd_frame_valid <= 1'b0;
         rd_new_frame   <= 1'b0;
         wr_base_addr   <= BASE_1;
         rd_base_addr   <= BASE_0;
      end else begin
         rd_new_frame <= take_c;
         case (state)
            S_WAIT_CALIB: if (init_done) state <= S_IDLE;
            S_IDLE:       if (fresh_c) state <= S_WRITING;
            S_WRITING:    if (done_c && !fresh_c) state <= S_IDLE;
            default:      state <= S_WAIT_CALIB;
         endcase
         if (run_c) begin
            wr_buf_idx   <= w_3_c;
            wr_base_addr <= base_of(w_3_c);
            rd_buf_idx   <= r_2_c;
            rd_base_addr <= base_of(r_2_c);
            l_idx        <= l_1_c;
            l_valid      <= lv_3_c;
            if (fresh_c) begin
               wr_active <= 1'b1;
            end else if (done_c) begin
               wr_active <= 1'b0;
            end
            if (take_c) begin
               rd_frame_valid <= 1'b1;
            end
         end
      end
   end

   fbs_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
      .PixelClk (PixelClk),
      .nRST     (nRST),
      .inc      (drop_inc_c),
      .count    (drop_cnt)
   );

   fbs_sat_counter #(.WIDTH(CNT_W)) u_repeat_cnt (
      .PixelClk (PixelClk),
      .nRST     (nRST),
      .inc      (rep_inc_c),
      .count    (repeat_cnt)
   );

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler. A behavioural model of the
// buffer-ownership rules predicts every cycle's outputs into a queue; a
// monitor compares them against the DUT after each clock edge, and matches
// every rd_new_frame pulse against a queue of expected handovers.
// Buffer count follows FBS_TRIPLE_BUFFER_EN, as in the design.
module tb_frame_buffer_scheduler;

   localparam int unsigned FW   = 153600;
   localparam int unsigned CW   = 8;
   localparam int          CMAX = (1 << CW) - 1;
`ifdef FBS_TRIPLE_BUFFER_EN
   localparam int          NB   = 3;
`else
   localparam int          NB   = 2;
`endif

   typedef struct packed {
      logic [1:0]  w;
      logic [1:0]  r;
      logic [20:0] wb;
      logic [20:0] rb;
      logic        wa;
      logic        rv;
      logic        nf;
      logic [7:0]  dc;
      logic [7:0]  rc;
   } snap_t;

   logic        PixelClk;
   logic        nRST;
   logic        init_done;
   logic        wr_frame_start;
   logic        wr_frame_done;
   logic        rd_frame_start;
   logic [1:0]  wr_buf_idx;
   logic [1:0]  rd_buf_idx;
   logic [20:0] wr_base_addr;
   logic [20:0] rd_base_addr;
   logic        wr_active;
   logic        rd_frame_valid;
   logic        rd_new_frame;
   logic [7:0]  drop_cnt;
   logic [7:0]  repeat_cnt;

   frame_buffer_scheduler #(.FRAME_WORDS(FW), .CNT_W(CW)) dut (
      .PixelClk       (PixelClk),
      .nRST           (nRST),
      .init_done      (init_done),
      .wr_frame_start (wr_frame_start),
      .wr_frame_done  (wr_frame_done),
      .rd_frame_start (rd_frame_start),
      .wr_buf_idx     (wr_buf_idx),
      .rd_buf_idx     (rd_buf_idx),
      .wr_base_addr   (wr_base_addr),
      .rd_base_addr   (rd_base_addr),
      .wr_active      (wr_active),
      .rd_frame_valid (rd_frame_valid),
      .rd_new_frame   (rd_new_frame),
      .drop_cnt       (drop_cnt),
      .repeat_cnt     (repeat_cnt)
   );

   initial PixelClk = 1'b0;
   always #5 PixelClk = ~PixelClk;

   int    n_cmp = 0;
   int    n_bad = 0;
   snap_t exp_q[$];
   int    ho_q[$];

   // Model: who owns what, in plain integers.
   int m_cal, m_wr, m_w, m_r, m_l, m_lv, m_rv, m_nf, m_dc, m_rc;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_reset();
      m_cal = 0; m_wr = 0; m_w = 1; m_r = 0; m_l = 0;
      m_lv = 0; m_rv = 0; m_nf = 0; m_dc = 0; m_rc = 0;
   endtask

   task automatic model_step(input bit ws, input bit wd, input bit rs);
      bit found;
      m_nf = 0;
      if (m_cal == 0) begin
         if (init_done) m_cal = 1;
         return;
      end
      // writer completion
      if (wd && m_wr != 0) begin
         if (m_lv != 0) m_dc = sat(m_dc);
         m_l = m_w; m_lv = 1; m_wr = 0;
      end
      // reader frame start
      if (rs) begin
         if (m_lv != 0) begin
            m_r = m_l; m_lv = 0; m_rv = 1; m_nf = 1;
            ho_q.push_back(m_r);
         end else if (m_rv != 0) begin
            m_rc = sat(m_rc);
         end
      end
      // writer frame start (ignored as an abort while writing)
      if (ws && m_wr == 0) begin
         if (NB == 2) begin
            if (m_lv != 0) begin
               m_lv = 0; m_dc = sat(m_dc);
            end
            m_w = 1 - m_r;
         end else begin
            found = 0;
            for (int i = 0; i < NB; i++) begin
               if (!found && i != m_r && !(m_lv != 0 && i == m_l)) begin
                  m_w = i; found = 1;
               end
            end
         end
         m_wr = 1;
      end
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.w  = 2'(m_w);
      s.r  = 2'(m_r);
      s.wb = 21'(m_w * FW);
      s.rb = 21'(m_r * FW);
      s.wa = 1'(m_wr);
      s.rv = 1'(m_rv);
      s.nf = 1'(m_nf);
      s.dc = 8'(m_dc);
      s.rc = 8'(m_rc);
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.w  = wr_buf_idx;
      s.r  = rd_buf_idx;
      s.wb = wr_base_addr;
      s.rb = rd_base_addr;
      s.wa = wr_active;
      s.rv = rd_frame_valid;
      s.nf = rd_new_frame;
      s.dc = drop_cnt;
      s.rc = repeat_cnt;
      return s;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("w=%0d r=%0d wb=%0d rb=%0d wa=%0b rv=%0b nf=%0b drop=%0d rep=%0d",
                       s.w, s.r, s.wb, s.rb, s.wa, s.rv, s.nf, s.dc, s.rc);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, predict the next rising edge.
   task automatic cycle_rst(input bit rn, input bit ws, input bit wd, input bit rs);
      @(negedge PixelClk);
      nRST           = rn;
      wr_frame_start = ws;
      wr_frame_done  = wd;
      rd_frame_start = rs;
      if (!rn) model_reset();
      else     model_step(ws, wd, rs);
      exp_q.push_back(model_snap());
   endtask

   task automatic cycle(input bit ws, input bit wd, input bit rs);
      cycle_rst(1'b1, ws, wd, rs);
   endtask

   task automatic settle();
      @(posedge PixelClk);
      #2;
   endtask

   // Monitor: per-cycle output comparison and handover matching.
   initial begin
      snap_t e;
      snap_t a;
      int    x;
      forever begin
         @(posedge PixelClk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = dut_snap();
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL cycle_outputs t=%0t: got %s | want %s", $time, fmt(a), fmt(e));
            end
         end
         if (rd_new_frame === 1'b1) begin
            n_cmp++;
            if (ho_q.size() == 0) begin
               n_bad++;
               $display("FAIL handover t=%0t: got unexpected rd_new_frame with rd_buf_idx=%0d, want no pulse",
                        $time, rd_buf_idx);
            end else begin
               x = ho_q.pop_front();
               if (32'(rd_buf_idx) != x) begin
                  n_bad++;
                  $display("FAIL handover t=%0t: got rd_buf_idx=%0d, want %0d", $time, rd_buf_idx, x);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_w;
      int second_w;
      bit ws, wd, rs;

      nRST           = 1'b0;
      init_done      = 1'b0;
      wr_frame_start = 1'b0;
      wr_frame_done  = 1'b0;
      rd_frame_start = 1'b0;
      model_reset();

      // Reset values while held in reset.
      #12;
      chk("reset_wr_idx",   wr_buf_idx, 1);
      chk("reset_rd_idx",   rd_buf_idx, 0);
      chk("reset_wr_base",  wr_base_addr, FW);
      chk("reset_rd_base",  rd_base_addr, 0);
      chk("reset_wr_active", wr_active, 0);
      chk("reset_rd_valid", rd_frame_valid, 0);
      chk("reset_counters", {drop_cnt, repeat_cnt}, 0);

      // Uncalibrated: every pulse is ignored.
      cycle_rst(1'b1, 0, 0, 0);
      cycle(1, 0, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 1);
      cycle(1, 1, 1);
      settle();
      chk("uncal_wr_active", wr_active, 0);
      chk("uncal_rd_valid",  rd_frame_valid, 0);
      chk("uncal_wr_idx",    wr_buf_idx, 1);
      chk("uncal_rd_idx",    rd_buf_idx, 0);

      init_done = 1'b1;
      cycle(0, 0, 0);

      // First frame handed to the reader.
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      settle();
      chk("first_rd_idx",   rd_buf_idx, 1);
      chk("first_rd_base",  rd_base_addr, FW);
      chk("first_new_pulse", rd_new_frame, 1);
      cycle(0, 0, 0);
      settle();
      chk("first_new_pulse_end", rd_new_frame, 0);
      chk("first_counters", {drop_cnt, repeat_cnt}, 0);

      // Two frames completed without a read: one is dropped.
      first_w  = 0;
      second_w = (NB == 3) ? 2 : 0;
      cycle(1, 0, 0);
      settle();
      chk("drop_first_wr_idx", wr_buf_idx, first_w);
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      settle();
      chk("drop_second_wr_idx", wr_buf_idx, second_w);
      chk("drop_second_wr_base", wr_base_addr, second_w * FW);
      cycle(0, 1, 0);
      settle();
      chk("drop_cnt_one", drop_cnt, 1);
      cycle(0, 0, 1);
      settle();
      chk("drop_rd_idx", rd_buf_idx, second_w);

      // Reader repeats with no new frame: repeat counter saturates.
      for (int i = 0; i < 300; i++) cycle(0, 0, 1);
      settle();
      chk("repeat_saturated", repeat_cnt, CMAX);
      chk("repeat_rd_idx", rd_buf_idx, second_w);

      // Writer done and reader start together: reader takes the new frame.
      cycle(1, 0, 0);
      settle();
      chk("same_cycle_wr_idx", wr_buf_idx, (NB == 3) ? 0 : 1);
      cycle(0, 0, 0);
      cycle(0, 1, 1);
      settle();
      chk("same_cycle_rd_idx", rd_buf_idx, (NB == 3) ? 0 : 1);
      chk("same_cycle_new",    rd_new_frame, 1);
      chk("same_cycle_drop",   drop_cnt, 1);
      chk("same_cycle_wr_active", wr_active, 0);
      cycle(1, 0, 0);
      settle();
      chk("after_same_cycle_drop", drop_cnt, 1);

      // Reset in the middle of a frame.
      cycle(0, 0, 0);
      @(posedge PixelClk);
      #2;
      nRST = 1'b0;
      model_reset();
      #1;
      chk("midreset_wr_active", wr_active, 0);
      chk("midreset_wr_idx",    wr_buf_idx, 1);
      chk("midreset_rd_idx",    rd_buf_idx, 0);
      chk("midreset_wr_base",   wr_base_addr, FW);
      chk("midreset_rd_base",   rd_base_addr, 0);
      chk("midreset_flags",     {rd_frame_valid, rd_new_frame}, 0);
      chk("midreset_counters",  {drop_cnt, repeat_cnt}, 0);
      cycle_rst(1'b0, 1, 0, 0);
      cycle_rst(1'b1, 1, 0, 0);
      settle();
      chk("postreset_calib_wait", wr_active, 0);
      cycle(1, 0, 0);
      settle();
      chk("postreset_wr_idx",    wr_buf_idx, 1);
      chk("postreset_wr_active", wr_active, 1);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         ws = ($urandom_range(0, 7) == 0);
         wd = !ws && ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 4) == 0);
         cycle(ws, wd, rs);
      end
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      settle();
      chk("expected_queue_drained", exp_q.size(), 0);
      chk("handover_queue_drained", ho_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
